// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display blocks.
// Holds the active-high glyph table (bit order gfedcba), the segment bit
// indices, and the state type used by the scan reader's capture FSM.
// The drivers and the reader both take their glyphs from here so the
// encode and decode tables cannot drift apart.
package seg7_pkg;

  // Segment bit positions within a 7-bit pattern
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Hex glyphs, active-high, bits gfedcba
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Capture FSM states of the scan reader
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HELD    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational inverse of the hex-to-7-segment table.
// Ports:
//   seg    in   7  active-high segment pattern, bit0=a .. bit6=g
//   nibble out  4  decoded hex value (0 when the pattern is not a glyph)
//   bad    out  1  pattern is not one of the 16 hex glyphs
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       bad
);

  // Table lookup; anything outside the 16 glyphs (blank included) is flagged
  always_comb begin
    nibble = 4'h0;
    bad    = 1'b0;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        bad    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: observes a time-multiplexed 7-segment bus and rebuilds
// the displayed hex digits into a frame delivered over valid/ready.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   seg_in      7-bit segment bus (bit0=a .. bit6=g)
//   dig_in      NDIG one-hot digit strobes, all-zero when blanked
//   out_data    captured frame, slot k at [4k+3:4k]
//   out_bad     per-slot "not a hex glyph" flags
//   out_valid   frame available; held with data until out_ready
//   out_ready   consumer accept
//   overflow    one-cycle pulse when a completed frame had to be dropped
//   strobe_err  one-cycle pulse at the start of a multi-hot strobe interval
//
// Timing: the counter is updated on the same edge that loads the input
// register, so cnt_q is the age (in cycles, saturating) of the registered
// sample. The state register is classified from the same next-values, so
// ST_CAPTURE is the cycle in which the registered sample first becomes
// SETTLE cycles old; the slot is written on the edge that ends that cycle.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int SETTLE     = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     dig_in,
  output logic [4*NDIG-1:0]   out_data,
  output logic [NDIG-1:0]     out_bad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                strobe_err
);

  localparam int              IDX_W     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [3:0]      SETTLE_C  = 4'(SETTLE);
  localparam logic [NDIG-1:0] FULL_MASK = {NDIG{1'b1}};

  // Strobe classification: 0 = zero-hot, 1 = one-hot, 2 = multi-hot
  function automatic logic [1:0] hot_class(input logic [NDIG-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          seen = 1'b1;
        end
      end else begin
        seen = seen;
      end
    end
    if (multi) begin
      return 2'd2;
    end else if (seen) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  // One-hot to binary slot index
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NDIG-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [6:0]        seg_d, seg_q;
  logic [NDIG-1:0]   dig_d, dig_q;
  logic [3:0]        cnt_d, cnt_q;
  logic              changed_s;
  logic              reach_s;
  scan_state_e       state_d, state_q;
  logic              capture_s;
  logic              frame_done_s;
  logic [IDX_W-1:0]  idx_s;
  logic [3:0]        dec_nibble_s;
  logic              dec_bad_s;
  logic [NDIG-1:0]   mask_d, mask_q;
  logic [4*NDIG-1:0] slot_d, slot_q;
  logic [NDIG-1:0]   bad_d, bad_q;
  logic [4*NDIG-1:0] out_data_d, out_data_q;
  logic [NDIG-1:0]   out_bad_d, out_bad_q;
  logic              out_valid_d, out_valid_q;
  logic              overflow_d, overflow_q;
  logic              strobe_err_d, strobe_err_q;

  seg7_glyph_decode u_decode (
    .seg    (seg_q),
    .nibble (dec_nibble_s),
    .bad    (dec_bad_s)
  );

  // Input polarity normalisation and sample-age counter
  always_comb begin
    if (ACTIVE_LOW) begin
      seg_d = ~seg_in;
      dig_d = ~dig_in;
    end else begin
      seg_d = seg_in;
      dig_d = dig_in;
    end
    changed_s = ({seg_d, dig_d} != {seg_q, dig_q});
    if (changed_s) begin
      cnt_d = 4'd1;
    end else if (cnt_q < SETTLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // "first reaches": either a fresh sample with SETTLE=1, or a climb onto SETTLE
    reach_s = (cnt_d == SETTLE_C) && (changed_s || (cnt_q != SETTLE_C));
  end

  // FSM next-state: one capture per stable one-hot interval
  always_comb begin
    state_d = ST_WAIT;
    case (state_q)
      ST_WAIT: begin
        if (reach_s && (hot_class(dig_d) == 2'd1)) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CAPTURE, ST_HELD: begin
        if (reach_s && (hot_class(dig_d) == 2'd1)) begin
          state_d = ST_CAPTURE;
        end else if (changed_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // FSM outputs: capture strobe and multi-hot entry detect
  always_comb begin
    capture_s    = (state_q == ST_CAPTURE);
    strobe_err_d = (hot_class(dig_d) == 2'd2) && (hot_class(dig_q) != 2'd2);
  end

  // Slot/mask update and output frame handshake
  always_comb begin
    idx_s        = onehot_to_idx(dig_q);
    frame_done_s = (mask_q == FULL_MASK);
    slot_d       = slot_q;
    bad_d        = bad_q;
    out_data_d   = out_data_q;
    out_bad_d    = out_bad_q;
    out_valid_d  = out_valid_q;
    overflow_d   = 1'b0;

    if (frame_done_s) begin
      mask_d = '0;
    end else begin
      mask_d = mask_q;
    end

    // A capture in the completion cycle starts the next frame
    if (capture_s) begin
      for (int k = 0; k < NDIG; k++) begin
        if (IDX_W'(k) == idx_s) begin
          slot_d[4*k +: 4] = dec_nibble_s;
          bad_d[k]         = dec_bad_s;
          mask_d[k]        = 1'b1;
        end else begin
          mask_d[k] = mask_d[k];
        end
      end
    end else begin
      mask_d = mask_d;
    end

    if (frame_done_s) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = slot_q;
        out_bad_d   = bad_q;
        out_valid_d = 1'b1;
      end else begin
        overflow_d  = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q        <= 7'h00;
      dig_q        <= '0;
      cnt_q        <= 4'd0;
      state_q      <= ST_WAIT;
      mask_q       <= '0;
      slot_q       <= '0;
      bad_q        <= '0;
      out_data_q   <= '0;
      out_bad_q    <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      slot_q       <= slot_d;
      bad_q        <= bad_d;
      out_data_q   <= out_data_d;
      out_bad_q    <= out_bad_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_bad    = out_bad_q;
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;
  assign strobe_err = strobe_err_q;

endmodule
